// File: rtl/chip8_vram_scanner_if.sv
// Pixel stream from the VRAM scanner to the LCD driver: RGB565 data with
// valid/ready handshake and frame first/last markers.
interface chip8_vram_scanner_if;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_first;
    logic        pix_last;

    modport master (
        output pix_data,
        output pix_valid,
        output pix_first,
        output pix_last,
        input  pix_ready
    );

    modport slave (
        input  pix_data,
        input  pix_valid,
        input  pix_first,
        input  pix_last,
        output pix_ready
    );
endinterface

// File: rtl/chip8_vram_scanner.sv
// Read-side scanner for the 64x32 CHIP-8 frame buffer: walks VRAM port B row by
// row and streams each bit as a SCALE x SCALE block of RGB565 pixels.
module chip8_vram_scanner #(
    parameter int          SCALE    = 4,
    parameter logic [15:0] FG_COLOR = 16'hFFFF,
    parameter logic [15:0] BG_COLOR = 16'h0000
) (
    input  logic                        CLOCK_50,
    input  logic                        reset,
    input  logic                        start,
    output logic                        busy,
    output logic                        frame_done,
    output logic [4:0]                  vram_address_out,
    input  logic [63:0]                 vram_data_in,
    output logic                        vram_wren_out,
    output logic [63:0]                 vram_wdata_out,
    chip8_vram_scanner_if.master        pix
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        LATCH,
        STREAM
    } state_t;

    localparam logic [2:0] SUB_LAST = 3'(SCALE - 1);

    state_t      state;
    state_t      state_next;
    logic [4:0]  row;
    logic [5:0]  x;
    logic [2:0]  sub_x;
    logic [2:0]  sub_y;
    logic [63:0] row_buf;

    logic xfer;
    logic sub_x_end;
    logic line_end;
    logic group_end;
    logic frame_end;

    assign xfer      = (state == STREAM) && pix.pix_ready;
    assign sub_x_end = (sub_x == SUB_LAST);
    assign line_end  = sub_x_end && (x == 6'd63);
    assign group_end = line_end && (sub_y == SUB_LAST);
    assign frame_end = group_end && (row == 5'd31);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = FETCH;
            FETCH:   state_next = LATCH;
            LATCH:   state_next = STREAM;
            STREAM:  if (xfer && group_end) state_next = frame_end ? IDLE : FETCH;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            busy             <= 1'b0;
            frame_done       <= 1'b0;
            vram_address_out <= 5'd0;
            row              <= 5'd0;
            x                <= 6'd0;
            sub_x            <= 3'd0;
            sub_y            <= 3'd0;
        end else begin
            frame_done <= 1'b0;
            if (state == IDLE && start) begin
                vram_address_out <= 5'd0;
                row              <= 5'd0;
                x                <= 6'd0;
                sub_x            <= 3'd0;
                sub_y            <= 3'd0;
                busy             <= 1'b1;
            end else if (xfer) begin
                // Odometer: sub_x -> x -> sub_y -> row; a finished row group
                // points the RAM at the next row while the FSM refetches.
                if (!sub_x_end) begin
                    sub_x <= sub_x + 3'd1;
                end else begin
                    sub_x <= 3'd0;
                    if (x != 6'd63) begin
                        x <= x + 6'd1;
                    end else begin
                        x <= 6'd0;
                        if (sub_y != SUB_LAST) begin
                            sub_y <= sub_y + 3'd1;
                        end else begin
                            sub_y <= 3'd0;
                            if (row != 5'd31) begin
                                row              <= row + 5'd1;
                                vram_address_out <= row + 5'd1;
                            end else begin
                                row        <= 5'd0;
                                busy       <= 1'b0;
                                frame_done <= 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    // NOTE: row_buf is deliberately not reset; it is always reloaded in LATCH
    // before STREAM can read it.
    always_ff @(posedge CLOCK_50) begin
        if (state == LATCH) begin
            row_buf <= vram_data_in;
        end
    end

    assign pix.pix_valid = (state == STREAM);
    assign pix.pix_data  = (state != STREAM) ? 16'h0000
                         : (row_buf[6'd63 - x] ? FG_COLOR : BG_COLOR);
    assign pix.pix_first = (state == STREAM) && (row == 5'd0) && (sub_y == 3'd0)
                         && (x == 6'd0) && (sub_x == 3'd0);
    assign pix.pix_last  = (state == STREAM) && frame_end;

    assign vram_wren_out  = 1'b0;
    assign vram_wdata_out = 64'd0;

endmodule

// File: tb/tb_chip8_vram_scanner.sv
// Scoreboard bench for chip8_vram_scanner: a frame-level reference model fills
// the expected pixel queue at each start; a negedge monitor pops and compares.
module tb_chip8_vram_scanner;

    localparam int          SCALE     = 2;
    localparam logic [15:0] FG        = 16'hFFFF;
    localparam logic [15:0] BG        = 16'h0000;
    localparam int          FRAME_PIX = 64 * 32 * SCALE * SCALE;
    localparam int          FRAME_CYC = 32 * (2 + 64 * SCALE * SCALE);

    typedef struct packed {
        logic [15:0] data;
        logic        first;
        logic        last;
    } pix_t;

    logic        CLOCK_50 = 1'b0;
    logic        reset    = 1'b1;
    logic        start    = 1'b0;
    logic        busy;
    logic        frame_done;
    logic [4:0]  vram_address_out;
    logic [63:0] vram_data_in = 64'd0;
    logic        vram_wren_out;
    logic [63:0] vram_wdata_out;

    chip8_vram_scanner_if pix ();

    chip8_vram_scanner #(
        .SCALE    (SCALE),
        .FG_COLOR (FG),
        .BG_COLOR (BG)
    ) dut (
        .CLOCK_50         (CLOCK_50),
        .reset            (reset),
        .start            (start),
        .busy             (busy),
        .frame_done       (frame_done),
        .vram_address_out (vram_address_out),
        .vram_data_in     (vram_data_in),
        .vram_wren_out    (vram_wren_out),
        .vram_wdata_out   (vram_wdata_out),
        .pix              (pix)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Port B of the frame buffer: address registered by the RAM, data one clock later.
    logic [63:0] vram [32];
    always @(posedge CLOCK_50) vram_data_in <= vram[vram_address_out];

    int   errors = 0;
    int   checks = 0;
    pix_t sb[$];
    bit   bp_en = 1'b0;
    int   frame_xfers = 0;
    int   last_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic finish_now();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    // Reference model: the whole frame in raster order, each VRAM bit repeated
    // SCALE times horizontally and each row repeated SCALE times vertically.
    task automatic push_frame();
        int   idx = 0;
        pix_t p;
        for (int r = 0; r < 32; r++)
            for (int sy = 0; sy < SCALE; sy++)
                for (int col = 0; col < 64; col++)
                    for (int sx = 0; sx < SCALE; sx++) begin
                        p.data  = vram[r][63 - col] ? FG : BG;
                        p.first = (idx == 0);
                        p.last  = (idx == FRAME_PIX - 1);
                        sb.push_back(p);
                        idx++;
                    end
    endtask

    initial begin
        pix.pix_ready = 1'b1;
        forever begin
            @(posedge CLOCK_50);
            #1;
            pix.pix_ready = bp_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
        end
    end

    // Monitor: transfer checks, hold-while-stalled checks, frame_done timing.
    pix_t held;
    bit   held_v  = 1'b0;
    bit   fd_pend = 1'b0;
    always @(negedge CLOCK_50) begin
        pix_t cur;
        pix_t exp;
        cur = {pix.pix_data, pix.pix_first, pix.pix_last};
        if (frame_done || fd_pend) check("frame_done_pulse", frame_done, fd_pend);
        if (held_v) begin
            check("hold_valid", pix.pix_valid, 1'b1);
            check("hold_payload", cur, held);
        end
        held_v  = 1'b0;
        fd_pend = 1'b0;
        if (!reset && pix.pix_valid) begin
            if (!pix.pix_ready) begin
                held_v = 1'b1;
                held   = cur;
            end else begin
                frame_xfers++;
                check("pixel_expected", sb.size() > 0, 1'b1);
                if (sb.size() > 0) begin
                    exp = sb.pop_front();
                    check("pixel", cur, exp);
                    fd_pend = exp.last;
                end
                if (pix.pix_last) last_seen++;
            end
        end
    end

    task automatic issue_start(input bit in_done_cycle);
        if (!in_done_cycle) begin
            @(posedge CLOCK_50);
            #1;
        end
        start       = 1'b1;
        frame_xfers = 0;
        last_seen   = 0;
        push_frame();
        @(posedge CLOCK_50);
        #1;
        start = 1'b0;
    endtask

    task automatic run_frame(input bit bp, input bit poke, input bit b2b, input bit timed);
        int         n = 0;
        int         bubbles;
        int         chg = 0;
        logic [4:0] pa;
        bp_en = bp;
        issue_start(b2b);
        @(negedge CLOCK_50);
        check("busy_after_start", busy, 1'b1);
        check("valid_in_fetch", pix.pix_valid, 1'b0);
        check("addr_row0", vram_address_out, 5'd0);
        bubbles = 1;
        pa      = vram_address_out;
        while (1) begin
            @(posedge CLOCK_50);
            n++;
            @(negedge CLOCK_50);
            if (n == 1) check("valid_in_latch", pix.pix_valid, 1'b0);
            if (n == 2) check("valid_after_3_edges", pix.pix_valid, 1'b1);
            if (poke && n == 500) start = 1'b1;
            if (poke && n == 501) start = 1'b0;
            if (busy && !pix.pix_valid) bubbles++;
            if (vram_address_out != pa) chg++;
            pa = vram_address_out;
            if (frame_done) break;
            if (n >= 60000) begin
                check("frame_done_within_bound", frame_done, 1'b1);
                finish_now();
            end
        end
        check("bubble_cycles", bubbles, 64);
        check("addr_changes", chg, 31);
        check("last_count", last_seen, 1);
        check("sb_drained", sb.size(), 0);
        check("busy_cleared", busy, 1'b0);
        if (timed) check("frame_cycles", n, FRAME_CYC);
    endtask

    initial begin
        int n;
        for (int r = 0; r < 32; r++) vram[r] = 64'd0;

        // Reset with start held high: reset wins, block stays idle.
        start = 1'b1;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_addr", vram_address_out, 5'd0);
        check("rst_wren", vram_wren_out, 1'b0);
        check("rst_wdata", vram_wdata_out, 64'd0);
        check("rst_valid", pix.pix_valid, 1'b0);
        check("rst_data", pix.pix_data, 16'h0000);
        check("rst_first", pix.pix_first, 1'b0);
        check("rst_last", pix.pix_last, 1'b0);
        @(posedge CLOCK_50);
        #1;
        start = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check("idle_busy", busy, 1'b0);
        check("idle_valid", pix.pix_valid, 1'b0);

        // Leftmost and rightmost pixels of row 0, no backpressure.
        vram[0] = 64'h8000_0000_0000_0001;
        run_frame(1'b0, 1'b0, 1'b0, 1'b1);

        // Single pixel on row 5: lines 10..11, columns 0..1 light up.
        vram[0] = 64'd0;
        vram[5] = 64'h8000_0000_0000_0000;
        run_frame(1'b0, 1'b0, 1'b0, 1'b1);

        // Random image with backpressure and a start poked mid-frame.
        for (int r = 0; r < 32; r++) vram[r] = {$urandom, $urandom};
        run_frame(1'b1, 1'b1, 1'b0, 1'b0);

        // Next frame requested in the frame_done cycle itself.
        for (int r = 0; r < 32; r++) vram[r] = {$urandom, $urandom};
        run_frame(1'b1, 1'b0, 1'b1, 1'b0);

        // Abort at transfer 1000 with a one-cycle reset.
        for (int r = 0; r < 32; r++) vram[r] = {$urandom, $urandom};
        bp_en = 1'b1;
        issue_start(1'b0);
        n = 0;
        while (frame_xfers < 1000) begin
            @(posedge CLOCK_50);
            #1;
            n++;
            if (n >= 20000) begin
                check("xfers_within_bound", frame_xfers >= 1000, 1'b1);
                finish_now();
            end
        end
        reset = 1'b1;
        sb.delete();
        @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        @(negedge CLOCK_50);
        check("abort_valid", pix.pix_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_frame_done", frame_done, 1'b0);
        repeat (10) @(negedge CLOCK_50);
        check("abort_stays_idle", busy, 1'b0);

        // Full frame from (0,0) after the abort.
        for (int r = 0; r < 32; r++) vram[r] = {$urandom, $urandom};
        run_frame(1'b0, 1'b0, 1'b0, 1'b1);

        repeat (5) @(negedge CLOCK_50);
        finish_now();
    end

endmodule
